// File: rtl/friscv_wb_arbiter.sv
// Write-back arbiter for the processing stage. The ALU and memfy streams each
// queue write-backs in a small FIFO, and a round-robin arbiter drains one
// entry per cycle onto the registered integer register-file write port.

// Small synchronous FIFO holding one requester's pending write-backs.
module friscv_wb_arbiter_fifo #(
    parameter int WIDTH      = 41,
    parameter int FIFO_DEPTH = 2
)(
    input  logic             aclk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             not_full
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic [CW-1:0]    count_r;

    // Storage array: written on push only, contents are irrelevant while empty.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_r[wptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge aclk) begin
        if (srst) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (pop) begin
                rptr_r <= rptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data  = mem_r[rptr_r];
    assign head_valid = (count_r != {CW{1'b0}});
    // Ready comes from the count before the edge: no same-cycle bypass when full.
    assign not_full   = (count_r < DEPTH_C);

endmodule

// Top level: two requester FIFOs, round-robin grant, registered write port.
module friscv_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
)(
    input  logic              aclk,
    input  logic              srst,
    input  logic              alu_wb_valid,
    output logic              alu_wb_ready,
    input  logic [4:0]        alu_wb_addr,
    input  logic [XLEN-1:0]   alu_wb_val,
    input  logic [XLEN/8-1:0] alu_wb_strb,
    input  logic              memfy_wb_valid,
    output logic              memfy_wb_ready,
    input  logic [4:0]        memfy_wb_addr,
    input  logic [XLEN-1:0]   memfy_wb_val,
    input  logic [XLEN/8-1:0] memfy_wb_strb,
    output logic              rf_wr,
    output logic [4:0]        rf_addr,
    output logic [XLEN-1:0]   rf_val,
    output logic [XLEN/8-1:0] rf_strb,
    output logic              wb_empty
);

    localparam int SW = XLEN / 8;
    localparam int EW = 5 + XLEN + SW;

    typedef enum logic {
        GRANT_ALU   = 1'b0,
        GRANT_MEMFY = 1'b1
    } grant_t;

    logic          alu_push_s;
    logic          memfy_push_s;
    logic [EW-1:0] alu_head_s;
    logic [EW-1:0] memfy_head_s;
    logic          alu_head_valid_s;
    logic          memfy_head_valid_s;
    logic          grant_alu_s;
    logic          grant_memfy_s;

    grant_t          last_grant_r;
    logic            rf_wr_r;
    logic [4:0]      rf_addr_r;
    logic [XLEN-1:0] rf_val_r;
    logic [SW-1:0]   rf_strb_r;

    // Writes to x0 complete the handshake but are dropped before the FIFO.
    assign alu_push_s   = alu_wb_valid & alu_wb_ready & (alu_wb_addr != 5'd0);
    assign memfy_push_s = memfy_wb_valid & memfy_wb_ready & (memfy_wb_addr != 5'd0);

    friscv_wb_arbiter_fifo #(
        .WIDTH      (EW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .aclk       (aclk),
        .srst       (srst),
        .push       (alu_push_s),
        .push_data  ({alu_wb_addr, alu_wb_val, alu_wb_strb}),
        .pop        (grant_alu_s),
        .head_data  (alu_head_s),
        .head_valid (alu_head_valid_s),
        .not_full   (alu_wb_ready)
    );

    friscv_wb_arbiter_fifo #(
        .WIDTH      (EW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_memfy_fifo (
        .aclk       (aclk),
        .srst       (srst),
        .push       (memfy_push_s),
        .push_data  ({memfy_wb_addr, memfy_wb_val, memfy_wb_strb}),
        .pop        (grant_memfy_s),
        .head_data  (memfy_head_s),
        .head_valid (memfy_head_valid_s),
        .not_full   (memfy_wb_ready)
    );

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        grant_alu_s   = 1'b0;
        grant_memfy_s = 1'b0;
        case ({alu_head_valid_s, memfy_head_valid_s})
            2'b10: begin
                grant_alu_s   = 1'b1;
                grant_memfy_s = 1'b0;
            end
            2'b01: begin
                grant_alu_s   = 1'b0;
                grant_memfy_s = 1'b1;
            end
            2'b11: begin
                if (last_grant_r == GRANT_MEMFY) begin
                    grant_alu_s   = 1'b1;
                    grant_memfy_s = 1'b0;
                end else begin
                    grant_alu_s   = 1'b0;
                    grant_memfy_s = 1'b1;
                end
            end
            default: begin
                grant_alu_s   = 1'b0;
                grant_memfy_s = 1'b0;
            end
        endcase
    end

    // Register the popped head onto the write port; payload holds when idle.
    always_ff @(posedge aclk) begin
        if (srst) begin
            rf_wr_r      <= 1'b0;
            rf_addr_r    <= 5'd0;
            rf_val_r     <= {XLEN{1'b0}};
            rf_strb_r    <= {SW{1'b0}};
            last_grant_r <= GRANT_MEMFY;
        end else if (grant_alu_s) begin
            rf_wr_r                           <= 1'b1;
            {rf_addr_r, rf_val_r, rf_strb_r}  <= alu_head_s;
            last_grant_r                      <= GRANT_ALU;
        end else if (grant_memfy_s) begin
            rf_wr_r                           <= 1'b1;
            {rf_addr_r, rf_val_r, rf_strb_r}  <= memfy_head_s;
            last_grant_r                      <= GRANT_MEMFY;
        end else begin
            rf_wr_r <= 1'b0;
        end
    end

    assign rf_wr    = rf_wr_r;
    assign rf_addr  = rf_addr_r;
    assign rf_val   = rf_val_r;
    assign rf_strb  = rf_strb_r;
    // Drain/fence status: nothing queued and no write on the port this cycle.
    assign wb_empty = ~alu_head_valid_s & ~memfy_head_valid_s & ~rf_wr_r;

endmodule

// File: tb/tb_friscv_wb_arbiter.sv
// Bench for friscv_wb_arbiter: accepted requests go into per-requester
// expected queues; a monitor pops and compares on every register-file write.
module tb_friscv_wb_arbiter;

    localparam int XLEN = 32;

    logic        aclk = 1'b0;
    logic        srst = 1'b1;
    logic        alu_wb_valid = 1'b0, memfy_wb_valid = 1'b0;
    logic        alu_wb_ready, memfy_wb_ready;
    logic [4:0]  alu_wb_addr = 5'd0, memfy_wb_addr = 5'd0;
    logic [31:0] alu_wb_val = 32'd0, memfy_wb_val = 32'd0;
    logic [3:0]  alu_wb_strb = 4'd0, memfy_wb_strb = 4'd0;
    logic        rf_wr, wb_empty;
    logic [4:0]  rf_addr;
    logic [31:0] rf_val;
    logic [3:0]  rf_strb;

    friscv_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(2)) dut (
        .aclk(aclk), .srst(srst),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
        .alu_wb_addr(alu_wb_addr), .alu_wb_val(alu_wb_val), .alu_wb_strb(alu_wb_strb),
        .memfy_wb_valid(memfy_wb_valid), .memfy_wb_ready(memfy_wb_ready),
        .memfy_wb_addr(memfy_wb_addr), .memfy_wb_val(memfy_wb_val), .memfy_wb_strb(memfy_wb_strb),
        .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_val(rf_val), .rf_strb(rf_strb),
        .wb_empty(wb_empty)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] val;
        logic [3:0]  strb;
        int          stamp;
    } ent_t;

    typedef struct {
        int          src;
        logic [4:0]  addr;
        logic [31:0] val;
        logic [3:0]  strb;
        int          e;
    } wr_t;

    ent_t qa[$];
    ent_t qm[$];
    wr_t  wlog[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    bit   mon_en = 1'b0;
    bit   last_a_acc = 1'b0, last_m_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Sampler: decides acceptance just before each rising edge, pushes expectations.
    initial begin
        bit a_acc, m_acc, rs;
        ent_t en;
        forever begin
            @(negedge aclk);
            #4;
            a_acc = (alu_wb_valid === 1'b1) && (alu_wb_ready === 1'b1);
            m_acc = (memfy_wb_valid === 1'b1) && (memfy_wb_ready === 1'b1);
            rs    = (srst === 1'b1);
            en.stamp = edge_cnt + 1;
            @(posedge aclk);
            edge_cnt++;
            if (rs) begin
                qa.delete();
                qm.delete();
            end else begin
                if (a_acc && alu_wb_addr != 5'd0) begin
                    en.addr = alu_wb_addr; en.val = alu_wb_val; en.strb = alu_wb_strb;
                    qa.push_back(en);
                end
                if (m_acc && memfy_wb_addr != 5'd0) begin
                    en.addr = memfy_wb_addr; en.val = memfy_wb_val; en.strb = memfy_wb_strb;
                    qm.push_back(en);
                end
            end
            last_a_acc = a_acc && !rs;
            last_m_acc = m_acc && !rs;
        end
    end

    // Monitor: compares every write with the queue heads and checks fairness/status.
    initial begin
        bit prev_wr = 1'b0;
        int prev_src = 2;
        int src;
        wr_t w;
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                src = 2;
                if (rf_wr === 1'b1) begin
                    n_checks++;
                    if (qa.size() > 0 && qa[0].addr === rf_addr && qa[0].val === rf_val && qa[0].strb === rf_strb) begin
                        src = 0; void'(qa.pop_front());
                    end else if (qm.size() > 0 && qm[0].addr === rf_addr && qm[0].val === rf_val && qm[0].strb === rf_strb) begin
                        src = 1; void'(qm.pop_front());
                    end else begin
                        n_fail++;
                        $display("FAIL rf_write edge=%0d actual addr=%0d val=0x%0h strb=0x%0h required=an expected queue head",
                                 edge_cnt, rf_addr, rf_val, rf_strb);
                    end
                    if (src == 0 && prev_wr && prev_src == 0)
                        chk("memfy_starved", (qm.size() > 0 && qm[0].stamp <= edge_cnt - 1) ? 64'd1 : 64'd0, 64'd0);
                    if (src == 1 && prev_wr && prev_src == 1)
                        chk("alu_starved", (qa.size() > 0 && qa[0].stamp <= edge_cnt - 1) ? 64'd1 : 64'd0, 64'd0);
                    w.src = src; w.addr = rf_addr; w.val = rf_val; w.strb = rf_strb; w.e = edge_cnt;
                    wlog.push_back(w);
                end else begin
                    chk("idle_with_pending",
                        ((qa.size() > 0 && qa[0].stamp <= edge_cnt - 1) ||
                         (qm.size() > 0 && qm[0].stamp <= edge_cnt - 1)) ? 64'd1 : 64'd0, 64'd0);
                end
                chk("wb_empty", {63'd0, wb_empty}, {63'd0, (qa.size() == 0 && qm.size() == 0 && rf_wr !== 1'b1)});
                chk("alu_ready", {63'd0, alu_wb_ready}, {63'd0, (qa.size() < 2)});
                chk("memfy_ready", {63'd0, memfy_wb_ready}, {63'd0, (qm.size() < 2)});
                prev_wr  = (rf_wr === 1'b1);
                prev_src = src;
            end
        end
    end

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] avl, input logic [3:0] as,
                         input logic mv, input logic [4:0] ma, input logic [31:0] mvl, input logic [3:0] ms);
        @(negedge aclk);
        alu_wb_valid = av; alu_wb_addr = aa; alu_wb_val = avl; alu_wb_strb = as;
        memfy_wb_valid = mv; memfy_wb_addr = ma; memfy_wb_val = mvl; memfy_wb_strb = ms;
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        srst = 1'b1; alu_wb_valid = 1'b0; memfy_wb_valid = 1'b0;
        @(posedge aclk);
        #1;
        chk("rst_rf_wr", {63'd0, rf_wr}, 64'd0);
        chk("rst_rf_addr", {59'd0, rf_addr}, 64'd0);
        chk("rst_rf_val", {32'd0, rf_val}, 64'd0);
        chk("rst_rf_strb", {60'd0, rf_strb}, 64'd0);
        chk("rst_wb_empty", {63'd0, wb_empty}, 64'd1);
        chk("rst_alu_ready", {63'd0, alu_wb_ready}, 64'd1);
        chk("rst_memfy_ready", {63'd0, memfy_wb_ready}, 64'd1);
        @(negedge aclk);
        srst = 1'b0;
    endtask

    initial begin
        int k, ai, mi, seq;
        logic av, mv;
        logic [4:0] aa, ma;
        logic [31:0] avl, mvl;
        logic [3:0] as, ms;
        int mlist[$];

        repeat (2) @(posedge aclk);
        do_reset();
        mon_en = 1'b1;

        // Reset drain: queued ALU write and a request at the reset edge both vanish.
        wlog.delete();
        drive(1'b1, 5'd3, 32'h33, 4'hF, 1'b0, 5'd0, 32'd0, 4'd0);
        chk("drain_acc_rd3", {63'd0, last_a_acc}, 64'd1);
        @(negedge aclk);
        srst = 1'b1; alu_wb_valid = 1'b1; alu_wb_addr = 5'd4; alu_wb_val = 32'h44;
        @(posedge aclk);
        #1;
        @(negedge aclk);
        srst = 1'b0; alu_wb_valid = 1'b0;
        idle(4);
        chk("drain_no_write", wlog.size(), 64'd0);
        chk("drain_wb_empty", {63'd0, wb_empty}, 64'd1);
        chk("drain_alu_ready", {63'd0, alu_wb_ready}, 64'd1);
        chk("drain_memfy_ready", {63'd0, memfy_wb_ready}, 64'd1);

        // Single stream: minimum latency of two edges.
        wlog.delete();
        drive(1'b1, 5'd5, 32'h0000_00AA, 4'hF, 1'b0, 5'd0, 32'd0, 4'd0);
        k = edge_cnt;
        idle(3);
        chk("single_count", wlog.size(), 64'd1);
        if (wlog.size() == 1) begin
            chk("single_addr", {59'd0, wlog[0].addr}, 64'd5);
            chk("single_val", {32'd0, wlog[0].val}, 64'hAA);
            chk("single_strb", {60'd0, wlog[0].strb}, 64'hF);
            chk("single_latency", wlog[0].e, k + 1);
        end
        chk("single_wb_empty", {63'd0, wb_empty}, 64'd1);

        // Contention from reset: ALU wins first, memfy next cycle.
        do_reset();
        wlog.delete();
        drive(1'b1, 5'd1, 32'h11, 4'hF, 1'b1, 5'd2, 32'h22, 4'hF);
        k = edge_cnt;
        idle(4);
        chk("cont_count", wlog.size(), 64'd2);
        if (wlog.size() == 2) begin
            chk("cont_first_addr", {59'd0, wlog[0].addr}, 64'd1);
            chk("cont_first_edge", wlog[0].e, k + 1);
            chk("cont_second_addr", {59'd0, wlog[1].addr}, 64'd2);
            chk("cont_second_edge", wlog[1].e, k + 2);
        end

        // Continuous contention: grants alternate starting with ALU.
        wlog.delete();
        ai = 0; mi = 0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 5'(10 + ai), 32'h100 + 32'(ai), 4'h3, 1'b1, 5'(20 + mi), 32'h200 + 32'(mi), 4'hC);
            if (last_a_acc) ai++;
            if (last_m_acc) mi++;
        end
        idle(8);
        chk("alt_enough_writes", (wlog.size() >= 8) ? 64'd1 : 64'd0, 64'd1);
        if (wlog.size() >= 8) begin
            chk("alt_first_alu", wlog[0].src, 64'd0);
            for (int j = 1; j < 8; j++) chk("alt_src", wlog[j].src, (j % 2 == 0) ? 64'd0 : 64'd1);
        end

        // Backpressure: memfy fills after two accepts while ALU keeps contending.
        do_reset();
        wlog.delete();
        ai = 0; mi = 0;
        for (int c = 0; c < 30 && mi < 3; c++) begin
            drive(1'b1, 5'(10 + (ai % 16)), 32'h300 + 32'(ai), 4'hF, 1'b1, 5'(7 + mi), 32'h700 + 32'(mi), 4'h5);
            if (last_a_acc) ai++;
            if (last_m_acc) begin
                mi++;
                if (mi == 2) chk("bp_memfy_ready_low", {63'd0, memfy_wb_ready}, 64'd0);
            end
        end
        chk("bp_all_accepted", mi, 64'd3);
        idle(10);
        mlist.delete();
        foreach (wlog[j]) if (wlog[j].src == 1) mlist.push_back(int'(wlog[j].addr));
        chk("bp_memfy_count", mlist.size(), 64'd3);
        if (mlist.size() == 3) begin
            chk("bp_order0", mlist[0], 64'd7);
            chk("bp_order1", mlist[1], 64'd8);
            chk("bp_order2", mlist[2], 64'd9);
        end

        // x0 filter: handshake completes, nothing is written.
        wlog.delete();
        drive(1'b1, 5'd0, 32'hDEAD, 4'hF, 1'b0, 5'd0, 32'd0, 4'd0);
        chk("x0_handshake", {63'd0, last_a_acc}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("x0_rf_wr", {63'd0, rf_wr}, 64'd0);
            chk("x0_wb_empty", {63'd0, wb_empty}, 64'd1);
        end
        chk("x0_no_write", wlog.size(), 64'd0);

        // Random soak with payload held until accepted.
        av = 1'b0; mv = 1'b0; aa = 5'd0; ma = 5'd0; avl = 32'd0; mvl = 32'd0; as = 4'd0; ms = 4'd0;
        seq = 0;
        last_a_acc = 1'b0; last_m_acc = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!av || last_a_acc) begin
                av = ($urandom_range(0, 3) != 0);
                aa = 5'($urandom_range(0, 31));
                avl = {1'b0, 31'(seq)};
                as = 4'($urandom_range(0, 15));
                seq++;
            end
            if (!mv || last_m_acc) begin
                mv = ($urandom_range(0, 3) != 0);
                ma = 5'($urandom_range(0, 31));
                mvl = {1'b1, 31'(seq)};
                ms = 4'($urandom_range(0, 15));
                seq++;
            end
            drive(av, aa, avl, as, mv, ma, mvl, ms);
        end
        idle(10);
        chk("soak_alu_drained", qa.size(), 64'd0);
        chk("soak_memfy_drained", qm.size(), 64'd0);
        chk("soak_wb_empty", {63'd0, wb_empty}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
